// File: rtl/ro_count_readout_if.sv
// ============================================================================
// Module   : ro_count_readout_if
// Purpose  : Counter-side and host-side signals of the RO readout sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ro_count_readout_if;
    logic        START;
    logic [31:0] INV_COUNT;
    logic [31:0] NAND_COUNT;
    logic [31:0] NOR_COUNT;
    logic        READ_DATA;
    logic        TX;
    logic        BUSY;
    logic        DONE;

    modport master (
        output START, INV_COUNT, NAND_COUNT, NOR_COUNT,
        input  READ_DATA, TX, BUSY, DONE
    );

    modport slave (
        input  START, INV_COUNT, NAND_COUNT, NOR_COUNT,
        output READ_DATA, TX, BUSY, DONE
    );
endinterface

`default_nettype wire

// File: rtl/ro_count_readout.sv
// ============================================================================
// Module   : ro_count_readout
// Purpose  : Clears/runs the RO counter, latches its three counts and ships
//            them as a 13-byte 8N1 UART frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_count_readout #(
    parameter int          CLR_CYCLES    = 4,
    parameter int          GATE_CYCLES   = 100000,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          BAUD_DIV      = 104,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  wire logic           CLK,
    input  wire logic           RST_N,
    ro_count_readout_if.slave   bus
);

    localparam int BW = $clog2(BAUD_DIV);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CLEAR  = 3'd1;
    localparam logic [2:0] c_ST_GATE   = 3'd2;
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_LATCH  = 3'd4;
    localparam logic [2:0] c_ST_SEND   = 3'd5;
    localparam logic [2:0] c_ST_FINISH = 3'd6;

    localparam logic [23:0]   c_CLR_LAST    = 24'(CLR_CYCLES - 1);
    localparam logic [23:0]   c_GATE_LAST   = 24'(GATE_CYCLES + 1);
    localparam logic [23:0]   c_SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] c_BAUD_LAST   = BW'(BAUD_DIV - 1);

    logic [2:0]    r_state;
    logic [23:0]   r_phase_cnt;
    logic [BW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_idx;
    logic [3:0]    r_byte_idx;
    logic [103:0]  r_frame;
    logic          r_read_data;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;

    logic [7:0]    w_cur_byte;
    logic          w_data_bit;

    // The byte on the wire is always the top of the frame shifter.
    assign w_cur_byte = r_frame[103:96];
    assign w_data_bit = w_cur_byte[r_bit_idx[2:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= c_ST_IDLE;
            r_phase_cnt <= '0;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_frame     <= '0;
            r_read_data <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.START) begin
                        r_state     <= c_ST_CLEAR;
                        r_read_data <= 1'b0;
                        r_busy      <= 1'b1;
                        r_phase_cnt <= '0;
                    end
                end
                c_ST_CLEAR: begin
                    if (r_phase_cnt == c_CLR_LAST) begin
                        r_state     <= c_ST_GATE;
                        r_read_data <= 1'b1;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 24'd1;
                    end
                end
                c_ST_GATE: begin
                    if (r_phase_cnt == c_GATE_LAST) begin
                        r_state     <= c_ST_SETTLE;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 24'd1;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_phase_cnt == c_SETTLE_LAST) begin
                        r_state     <= c_ST_LATCH;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 24'd1;
                    end
                end
                c_ST_LATCH: begin
                    r_frame    <= {HEADER, bus.INV_COUNT, bus.NAND_COUNT, bus.NOR_COUNT};
                    r_state    <= c_ST_SEND;
                    r_tx       <= 1'b0;
                    r_baud_cnt <= '0;
                    r_bit_idx  <= '0;
                    r_byte_idx <= '0;
                end
                c_ST_SEND: begin
                    if (r_baud_cnt == c_BAUD_LAST) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 4'd9) begin
                            if (r_byte_idx == 4'd12) begin
                                r_state <= c_ST_FINISH;
                                r_done  <= 1'b1;
                                r_tx    <= 1'b1;
                            end else begin
                                // Next byte's start bit follows the stop bit directly.
                                r_byte_idx <= r_byte_idx + 4'd1;
                                r_bit_idx  <= '0;
                                r_tx       <= 1'b0;
                                r_frame    <= {r_frame[95:0], 8'h00};
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : w_data_bit;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_FINISH: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.READ_DATA = r_read_data;
    assign bus.TX        = r_tx;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ro_count_readout.sv
// ============================================================================
// Module   : tb_ro_count_readout
// Purpose  : Self-checking bench for ro_count_readout against a timeline model
//            and an independent UART decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ro_count_readout;
    localparam int CLR    = 4;
    localparam int GATE   = 20;
    localparam int SETTLE = 4;
    localparam int BAUD   = 4;
    localparam int LAT    = CLR + GATE + SETTLE + 3;   // LATCH cycle, counted from START
    localparam int FIN    = LAT + 130 * BAUD + 1;      // DONE cycle
    localparam int PER    = FIN + 1;                   // first IDLE cycle / re-trigger period
    localparam int MAXREC = 2 * PER + 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ro_count_readout_if bus ();

    ro_count_readout #(
        .CLR_CYCLES    (CLR),
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .BAUD_DIV      (BAUD),
        .HEADER        (8'hA5)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_frame [13];
    logic [7:0] dec [$];
    logic       rec_tx [MAXREC+1];
    int e_rd, e_tx, e_busy, e_done, n_done, e_frm;

    task automatic set_counts(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [95:0] all;
        bus.INV_COUNT  = a;
        bus.NAND_COUNT = b;
        bus.NOR_COUNT  = c;
        all = {a, b, c};
        exp_frame[0] = 8'hA5;
        for (int i = 0; i < 12; i++) exp_frame[i+1] = all[95 - 8*i -: 8];
    endtask

    // Expected TX level at cycle m of a run (m = 1 is the first CLEAR cycle).
    function automatic logic model_tx(input int m);
        int p;
        int bn;
        logic [7:0] by;
        if (m <= LAT || m > LAT + 130 * BAUD) return 1'b1;
        p  = (m - LAT - 1) / BAUD;
        bn = p % 10;
        if (bn == 0) return 1'b0;
        if (bn == 9) return 1'b1;
        by = exp_frame[p / 10];
        return by[bn - 1];
    endfunction

    task automatic decode(input int nrec);
        int i;
        logic [7:0] b;
        dec.delete();
        e_frm = 0;
        i = 1;
        while (i + 10 * BAUD - 1 <= nrec) begin
            if (rec_tx[i] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = rec_tx[i + BAUD * (k + 1) + BAUD / 2];
                if (rec_tx[i + 9 * BAUD + BAUD / 2] !== 1'b1) e_frm++;
                dec.push_back(b);
                i += 10 * BAUD;
            end else begin
                i++;
            end
        end
    endtask

    // Issue START, record nrec cycles and score them against the timeline model.
    task automatic run_capture(input int nrec, input bit hold, input int p1, input int p2, input int chg);
        int m;
        e_rd = 0; e_tx = 0; e_busy = 0; e_done = 0; n_done = 0;
        @(negedge clk);
        bus.START = 1'b1;
        for (int n = 1; n <= nrec; n++) begin
            @(negedge clk);
            m = hold ? ((n - 1) % PER) + 1 : ((n < PER) ? n : PER);
            rec_tx[n] = bus.TX;
            if (bus.READ_DATA !== (m > CLR))  e_rd++;
            if (bus.TX        !== model_tx(m)) e_tx++;
            if (bus.BUSY      !== (m <= FIN)) e_busy++;
            if (bus.DONE      !== (m == FIN)) e_done++;
            if (bus.DONE      === 1'b1)       n_done++;
            bus.START = (hold && n < nrec) || n == p1 || n == p2;
            if (n == chg) begin
                bus.INV_COUNT  = 32'hFFFF_FFFF;
                bus.NAND_COUNT = 32'hFFFF_FFFF;
                bus.NOR_COUNT  = 32'hFFFF_FFFF;
            end
        end
        bus.START = 1'b0;
        decode(nrec);
    endtask

    task automatic test_reset;
        bus.START = 1'b0;
        set_counts(32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checks++; if (bus.TX !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b want 1", bus.TX); end
        checks++; if (bus.READ_DATA !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", bus.READ_DATA); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.BUSY !== 1'b0)      begin errors++; $display("FAIL idle_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0)      begin errors++; $display("FAIL idle_done: got %b want 0", bus.DONE); end
        checks++; if (bus.READ_DATA !== 1'b0) begin errors++; $display("FAIL idle_rd: got %b want 0", bus.READ_DATA); end
    endtask

    task automatic test_basic_frame;
        set_counts(32'h0123_4567, 32'h89AB_CDEF, 32'h0000_0000);
        run_capture(PER + 4, 1'b0, 0, 0, 0);
        checks++; if (e_rd   !== 0) begin errors++; $display("FAIL basic_rd: %0d bad cycles want 0", e_rd); end
        checks++; if (e_tx   !== 0) begin errors++; $display("FAIL basic_tx: %0d bad cycles want 0", e_tx); end
        checks++; if (e_busy !== 0) begin errors++; $display("FAIL basic_busy: %0d bad cycles want 0", e_busy); end
        checks++; if (e_done !== 0) begin errors++; $display("FAIL basic_done_timing: %0d bad cycles want 0", e_done); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
        checks++; if (e_frm  !== 0) begin errors++; $display("FAIL basic_stop_bits: %0d bad want 0", e_frm); end
        checks++; if (dec.size() !== 13) begin errors++; $display("FAIL basic_len: got %0d want 13", dec.size()); end
        for (int i = 0; i < 13 && i < dec.size(); i++) begin
            checks++;
            if (dec[i] !== exp_frame[i]) begin
                errors++; $display("FAIL basic_byte%0d: got %02h want %02h", i, dec[i], exp_frame[i]);
            end
        end
    endtask

    task automatic test_random_frames;
        for (int r = 0; r < 3; r++) begin
            set_counts($urandom, $urandom, $urandom);
            run_capture(PER + 4, 1'b0, 0, 0, 0);
            checks++;
            if (e_rd + e_tx + e_busy + e_done !== 0) begin
                errors++; $display("FAIL rand%0d_timeline: rd=%0d tx=%0d busy=%0d done=%0d want all 0", r, e_rd, e_tx, e_busy, e_done);
            end
            checks++;
            if (dec.size() !== 13 || dec[12] !== exp_frame[12] || dec[1] !== exp_frame[1]) begin
                errors++; $display("FAIL rand%0d_decode: len=%0d want 13", r, dec.size());
            end
        end
    endtask

    task automatic test_start_ignored;
        set_counts($urandom, $urandom, $urandom);
        run_capture(PER + 40, 1'b0, $urandom_range(CLR + 2, CLR + GATE),
                    $urandom_range(LAT + 10, LAT + 120 * BAUD), 0);
        checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
        checks++; if (dec.size() !== 13) begin errors++; $display("FAIL ignore_len: got %0d want 13", dec.size()); end
        checks++;
        if (e_tx + e_busy + e_rd !== 0) begin
            errors++; $display("FAIL ignore_timeline: tx=%0d busy=%0d rd=%0d want 0", e_tx, e_busy, e_rd);
        end
    endtask

    task automatic test_count_change;
        int bad;
        set_counts($urandom, $urandom, $urandom);
        run_capture(PER + 4, 1'b0, 0, 0, LAT + 1);
        bad = 0;
        for (int i = 0; i < 13 && i < dec.size(); i++) if (dec[i] !== exp_frame[i]) bad++;
        checks++; if (dec.size() !== 13) begin errors++; $display("FAIL latch_len: got %0d want 13", dec.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL latch_bytes: %0d wrong bytes want 0", bad); end
        checks++; if (e_tx !== 0) begin errors++; $display("FAIL latch_tx: %0d bad cycles want 0", e_tx); end
    endtask

    task automatic test_reset_mid_send;
        logic tx_before;
        logic rd_before;
        int   dones;
        set_counts($urandom, $urandom, $urandom);
        @(negedge clk); bus.START = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        // Now at cycle 1; move into the start bit of byte 5.
        repeat (LAT + 5 * 10 * BAUD + 1) @(negedge clk);
        tx_before = bus.TX;
        rd_before = bus.READ_DATA;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_before !== 1'b0) begin errors++; $display("FAIL abort_pre_tx: got %b want 0", tx_before); end
        checks++; if (rd_before !== 1'b1) begin errors++; $display("FAIL abort_pre_rd: got %b want 1", rd_before); end
        checks++; if (bus.TX !== 1'b1)        begin errors++; $display("FAIL abort_async_tx: got %b want 1", bus.TX); end
        checks++; if (bus.READ_DATA !== 1'b0) begin errors++; $display("FAIL abort_async_rd: got %b want 0", bus.READ_DATA); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) dones++;
        end
        checks++; if (dones !== 0)      begin errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.BUSY); end
        set_counts($urandom, $urandom, $urandom);
        run_capture(PER + 4, 1'b0, 0, 0, 0);
        checks++;
        if (e_rd + e_tx + e_busy + e_done !== 0 || n_done !== 1) begin
            errors++; $display("FAIL abort_rerun: rd=%0d tx=%0d busy=%0d done=%0d pulses=%0d want 0/0/0/0/1", e_rd, e_tx, e_busy, e_done, n_done);
        end
        checks++; if (dec.size() !== 13 || dec[5] !== exp_frame[5]) begin errors++; $display("FAIL abort_rerun_decode: len=%0d want 13", dec.size()); end
    endtask

    task automatic test_back_to_back;
        int bad;
        set_counts($urandom, $urandom, $urandom);
        run_capture(2 * PER - 1, 1'b1, 0, 0, 0);
        checks++; if (e_rd   !== 0) begin errors++; $display("FAIL b2b_rd: %0d bad cycles want 0", e_rd); end
        checks++; if (e_tx   !== 0) begin errors++; $display("FAIL b2b_tx: %0d bad cycles want 0", e_tx); end
        checks++; if (e_busy + e_done !== 0) begin errors++; $display("FAIL b2b_busy_done: busy=%0d done=%0d want 0", e_busy, e_done); end
        checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        checks++; if (dec.size() !== 26) begin errors++; $display("FAIL b2b_len: got %0d want 26", dec.size()); end
        bad = 0;
        for (int i = 0; i < 26 && i < dec.size(); i++) if (dec[i] !== exp_frame[i % 13]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_bytes: %0d wrong bytes want 0", bad); end
        repeat (20) @(negedge clk);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b want 0", bus.BUSY); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_random_frames();
        test_start_ignored();
        test_count_change();
        test_reset_mid_send();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ro_count_readout.md
# ro_count_readout

Measurement sequencer and serial readout stage that sits directly downstream of the ring-oscillator frequency counter. On a START request it drives the counter's active-low clear/run line, waits out the counting gate plus a settling margin, and latches the three 32-bit edge counts (INV, NAND, NOR). It then ships them to the host as a 13-byte UART frame (8N1). The only interface is one clock domain toward the counter and one TX pin toward the host.

## Interface
Parameters:
- CLR_CYCLES, 4: cycles READ_DATA is held low to clear the counter (min 2)
- GATE_CYCLES, 100000: counter gate length in CLK cycles; must match the counter's gate
- SETTLE_CYCLES, 16: extra wait after the gate so the asynchronous RO-clocked counts are static (min 4)
- BAUD_DIV, 104: CLK cycles per UART bit (1 MHz / 104 ≈ 9600 baud; min 2)
- HEADER, 8'hA5: first byte of every frame

Ports:
- CLK  in  1  system clock (1 MHz nominal)
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  level-sampled request; accepted only in IDLE
- INV_COUNT  in  32  inverter RO count from the counter
- NAND_COUNT  in  32  NAND RO count
- NOR_COUNT  in  32  NOR RO count
- READ_DATA  out  1  to the counter: 0 = clear/hold in reset, 1 = run/hold
- TX  out  1  UART serial out, idle high
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse after the last stop bit

## Operation
- Reset values: state IDLE, READ_DATA=0, TX=1, BUSY=0, DONE=0, latched counts 0, all internal counters 0.
- States: IDLE -> CLEAR -> GATE -> SETTLE -> LATCH -> SEND -> FINISH -> IDLE.
- IDLE: READ_DATA keeps its previous value (0 after reset, 1 after a completed run), so the previous counts stay frozen. START=1 -> CLEAR.
- CLEAR: READ_DATA=0 for exactly CLR_CYCLES cycles, then GATE.
- GATE: READ_DATA=1 for GATE_CYCLES+2 cycles. The +2 covers the counter's enable-drop latency. Then SETTLE.
- SETTLE: READ_DATA=1, wait SETTLE_CYCLES cycles, then LATCH.
- LATCH: one cycle; capture {INV_COUNT, NAND_COUNT, NOR_COUNT} into a 96-bit holding register. The inputs are not re-sampled after this.
- SEND: transmit 13 bytes, in order: HEADER, INV[31:24..7:0], NAND[31:24..7:0], NOR[31:24..7:0]. Bytes are big-endian. Each byte is a start bit (0), 8 data bits LSB first, and a stop bit (1); each bit lasts BAUD_DIV cycles. There is no gap between bytes.
- FINISH: one cycle, DONE=1, then IDLE. READ_DATA stays 1.
- START outside IDLE is ignored, with no queuing. START held high continuously re-triggers at each IDLE visit.
- Counter widths: phase counter 24 bits (≥ GATE_CYCLES+2), baud counter ≥ clog2(BAUD_DIV), bit index 0..9, byte index 0..12.

## Timing
- START sampled high at edge k: CLEAR occupies cycles k+1 .. k+CLR_CYCLES (READ_DATA=0).
- GATE and SETTLE occupy the next GATE_CYCLES+2+SETTLE_CYCLES cycles (READ_DATA=1).
- LATCH is at cycle L = k+CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+3.
- The start bit of HEADER drives TX from cycle L+1.
- The last stop bit ends at L+130·BAUD_DIV. DONE=1 in cycle L+130·BAUD_DIV+1, and BUSY falls in the same cycle that DONE falls.
- All outputs are registered: no combinational path from any input to an output.
- Asynchronous reset mid-operation (any state): TX=1 and READ_DATA=0 immediately, without waiting for a clock edge. Any partial frame is abandoned and no DONE is produced. The next START after reset release runs a full sequence.
- A count input changing during SEND has no effect on the frame in flight.

## Test plan
- Basic frame (GATE_CYCLES=20, SETTLE_CYCLES=4, CLR_CYCLES=4, BAUD_DIV=4): counts 32'h01234567 / 32'h89ABCDEF / 32'h00000000, 1-cycle START -> UART decode yields A5 01 23 45 67 89 AB CD EF 00 00 00 00; DONE pulses exactly once at L+521.
- READ_DATA shape: READ_DATA is low for exactly 4 cycles starting the cycle after START, then high through DONE and afterwards; BUSY is high from k+1 to L+521.
- START pulsed during GATE and again during SEND -> no extra frame; exactly 13 bytes are sent.
- Count inputs changed to 32'hFFFFFFFF one cycle after LATCH -> the frame still carries the latched values.
- RST_N asserted mid-byte 5 of SEND -> TX=1 and READ_DATA=0 asynchronously, no DONE; a subsequent START produces a complete, correct frame.
- START held high across two runs -> back-to-back frames, each preceded by a fresh 4-cycle CLEAR; both frames decode correctly.
